// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // Controller FSM: RUN is normal flow, WAIT holds the pipe on a slow SRAM access.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int REG_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    // Increment applied to a statistics counter that has not yet saturated.
    localparam int unsigned SAT_STEP = 1;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundles pipeline event inputs and stall/flush controls for pipeline_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = pipeline side driving events, slave = controller.
// Signals: fwd_en, id_src1/2, id_use_src1/2, exe/mem_wb_en, exe/mem_dest,
//          exe_mem_read, branch_taken, mem_req, mem_ready (events);
//          freeze_front, freeze_back, flush_ifid, flush_idex, mem_busy and
//          the three statistics counters (controls / status).
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             fwd_en;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic             exe_wb_en;
    logic             mem_wb_en;
    logic [REG_W-1:0] exe_dest;
    logic [REG_W-1:0] mem_dest;
    logic             exe_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             freeze_front;
    logic             freeze_back;
    logic             flush_ifid;
    logic             flush_idex;
    logic             mem_busy;
    logic [CNT_W-1:0] hazard_stalls;
    logic [CNT_W-1:0] mem_stall_cycles;
    logic [CNT_W-1:0] branch_flushes;

    modport master (
        output fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
               exe_wb_en, mem_wb_en, exe_dest, mem_dest, exe_mem_read,
               branch_taken, mem_req, mem_ready,
        input  freeze_front, freeze_back, flush_ifid, flush_idex, mem_busy,
               hazard_stalls, mem_stall_cycles, branch_flushes
    );

    modport slave (
        input  fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
               exe_wb_en, mem_wb_en, exe_dest, mem_dest, exe_mem_read,
               branch_taken, mem_req, mem_ready,
        output freeze_front, freeze_back, flush_ifid, flush_idex, mem_busy,
               hazard_stalls, mem_stall_cycles, branch_flushes
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detector for the instruction sitting in ID.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides whether the hazard bit is acted on.
// Ports: fwd_en, id_src1/2 + id_use_src1/2 (consumer), exe/mem dest + wb_en
//        (producers), exe_mem_read (EXE is a load) -> hazard.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             fwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             exe_mem_read,
    output logic             hazard
);

    logic exe_hit;
    logic mem_hit;

    // A producer conflicts when it writes back and either live source reads its destination.
    always_comb begin
        exe_hit = exe_wb_en && ((id_use_src1 && (id_src1 == exe_dest)) ||
                                (id_use_src2 && (id_src2 == exe_dest)));
        mem_hit = mem_wb_en && ((id_use_src1 && (id_src1 == mem_dest)) ||
                                (id_use_src2 && (id_src2 == mem_dest)));
    end

    // With forwarding only a load in EXE cannot be bypassed in time (load-use);
    // without it, any pending write in EXE or MEM must drain first.
    always_comb begin
        if (fwd_en) begin
            hazard = exe_mem_read && exe_hit;
        end else begin
            hazard = exe_hit || mem_hit;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: memory waits, taken branches, RAW hazards.
// Latency: controls are same-cycle combinational; state/counters update next clk.
// Backpressure: a slow SRAM access freezes the whole pipe until mem_ready.
// Ports: clk, rst (sync, active-high), bus (pipeline_ctrl_if.slave) carrying
//        the hazard/branch/memory events in and freeze/flush/status out.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    state_t           state;
    logic             hazard;
    logic             mem_freeze;
    logic             branch_flush;
    logic             hazard_stall;
    logic [CNT_W-1:0] hazard_stalls_q;
    logic [CNT_W-1:0] mem_stall_cycles_q;
    logic [CNT_W-1:0] branch_flushes_q;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .fwd_en       (bus.fwd_en),
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_use_src1  (bus.id_use_src1),
        .id_use_src2  (bus.id_use_src2),
        .exe_wb_en    (bus.exe_wb_en),
        .mem_wb_en    (bus.mem_wb_en),
        .exe_dest     (bus.exe_dest),
        .mem_dest     (bus.mem_dest),
        .exe_mem_read (bus.exe_mem_read),
        .hazard       (hazard)
    );

    // Priority: memory freeze > branch flush > hazard stall. mem_req is a don't-care
    // in WAIT because the MEM stage is frozen on the same access. Everything is
    // masked during reset so the pipe registers see a clean cycle.
    always_comb begin
        mem_freeze   = 1'b0;
        branch_flush = 1'b0;
        hazard_stall = 1'b0;
        if (!rst) begin
            if (state == ST_WAIT) begin
                mem_freeze = !bus.mem_ready;
            end else begin
                mem_freeze = bus.mem_req && !bus.mem_ready;
            end
            // A branch held in EXE during WAIT is flushed in the mem_ready cycle.
            branch_flush = bus.branch_taken && !mem_freeze;
            hazard_stall = hazard && !mem_freeze && !bus.branch_taken;
        end
    end

    assign bus.freeze_front = mem_freeze || hazard_stall;
    assign bus.freeze_back  = mem_freeze;
    assign bus.flush_ifid   = branch_flush;
    // The hazard bubble is inserted by clearing ID/EX while IF/ID holds.
    assign bus.flush_idex   = branch_flush || hazard_stall;
    assign bus.mem_busy     = !rst && (state == ST_WAIT) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (bus.mem_req && !bus.mem_ready) state <= ST_WAIT;
                ST_WAIT: if (bus.mem_ready)                 state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    // Debug statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_stalls_q    <= '0;
            mem_stall_cycles_q <= '0;
            branch_flushes_q   <= '0;
        end else begin
            if (hazard_stall && (hazard_stalls_q != '1)) begin
                hazard_stalls_q <= hazard_stalls_q + CNT_W'(SAT_STEP);
            end
            if (mem_freeze && (mem_stall_cycles_q != '1)) begin
                mem_stall_cycles_q <= mem_stall_cycles_q + CNT_W'(SAT_STEP);
            end
            if (branch_flush && (branch_flushes_q != '1)) begin
                branch_flushes_q <= branch_flushes_q + CNT_W'(SAT_STEP);
            end
        end
    end

    assign bus.hazard_stalls    = hazard_stalls_q;
    assign bus.mem_stall_cycles = mem_stall_cycles_q;
    assign bus.branch_flushes   = branch_flushes_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes expected responses, monitor compares.
// Latency: checks same-cycle controls and next-cycle counter updates.
// Backpressure: n/a (bench drives every cycle).
module tb_pipeline_ctrl;

    typedef struct {
        bit       rst;
        bit       fwd_en;
        bit [3:0] src1;
        bit [3:0] src2;
        bit       use1;
        bit       use2;
        bit       exe_wb;
        bit       mem_wb;
        bit [3:0] exe_dest;
        bit [3:0] mem_dest;
        bit       exe_mem_read;
        bit       branch;
        bit       mem_req;
        bit       mem_ready;
    } stim_t;

    typedef struct {
        int cyc;
        bit ff;
        bit fb;
        bit fi;
        bit fx;
        bit busy;
        int hz;
        int ms;
        int bf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_W(4), .CNT_W(16)) b16 ();
    pipeline_ctrl_if #(.REG_W(4), .CNT_W(2))  b2 ();

    pipeline_ctrl #(.CNT_W(16), .REG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b16.slave)
    );

    pipeline_ctrl #(.CNT_W(2), .REG_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    // Narrow-counter instance sees exactly the same events.
    assign b2.fwd_en       = b16.fwd_en;
    assign b2.id_src1      = b16.id_src1;
    assign b2.id_src2      = b16.id_src2;
    assign b2.id_use_src1  = b16.id_use_src1;
    assign b2.id_use_src2  = b16.id_use_src2;
    assign b2.exe_wb_en    = b16.exe_wb_en;
    assign b2.mem_wb_en    = b16.mem_wb_en;
    assign b2.exe_dest     = b16.exe_dest;
    assign b2.mem_dest     = b16.mem_dest;
    assign b2.exe_mem_read = b16.exe_mem_read;
    assign b2.branch_taken = b16.branch_taken;
    assign b2.mem_req      = b16.mem_req;
    assign b2.mem_ready    = b16.mem_ready;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    // Reference model state: are we parked on a slow memory access, and raw event tallies.
    bit m_waiting = 1'b0;
    int m_haz     = 0;
    int m_mem     = 0;
    int m_br      = 0;

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string nm, input int c, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL cyc %0d %s got %0d expected %0d", c, nm, got, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Apply one cycle of stimulus, predict the response, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        int   producers[$];
        bit   mem_stall;
        bit   haz;
        @(posedge clk);
        #1;
        cyc++;
        rst              = s.rst;
        b16.fwd_en       = s.fwd_en;
        b16.id_src1      = s.src1;
        b16.id_src2      = s.src2;
        b16.id_use_src1  = s.use1;
        b16.id_use_src2  = s.use2;
        b16.exe_wb_en    = s.exe_wb;
        b16.mem_wb_en    = s.mem_wb;
        b16.exe_dest     = s.exe_dest;
        b16.mem_dest     = s.mem_dest;
        b16.exe_mem_read = s.exe_mem_read;
        b16.branch_taken = s.branch;
        b16.mem_req      = s.mem_req;
        b16.mem_ready    = s.mem_ready;

        // Registers whose pending write the ID instruction may not read yet.
        if (!s.fwd_en) begin
            if (s.exe_wb) producers.push_back(int'(s.exe_dest));
            if (s.mem_wb) producers.push_back(int'(s.mem_dest));
        end else if (s.exe_mem_read && s.exe_wb) begin
            producers.push_back(int'(s.exe_dest));
        end
        haz = 1'b0;
        foreach (producers[i]) begin
            if (s.use1 && producers[i] == int'(s.src1)) haz = 1'b1;
            if (s.use2 && producers[i] == int'(s.src2)) haz = 1'b1;
        end

        // A slow access stalls on entry and on every further not-ready cycle.
        mem_stall = m_waiting ? !s.mem_ready : (s.mem_req && !s.mem_ready);

        e = '{default: 0};
        e.cyc = cyc;
        e.hz  = m_haz;
        e.ms  = m_mem;
        e.bf  = m_br;
        if (!s.rst) begin
            e.busy = m_waiting && !s.mem_ready;
            if (mem_stall) begin
                e.ff = 1'b1;
                e.fb = 1'b1;
            end else if (s.branch) begin
                e.fi = 1'b1;
                e.fx = 1'b1;
            end else if (haz) begin
                e.ff = 1'b1;
                e.fx = 1'b1;
            end
        end
        exp_q.push_back(e);

        if (s.rst) begin
            m_waiting = 1'b0;
            m_haz     = 0;
            m_mem     = 0;
            m_br      = 0;
        end else begin
            m_waiting = mem_stall;
            if (e.fb)                 m_mem++;
            if (e.fi)                 m_br++;
            if (e.ff && !e.fb)        m_haz++;
        end
    endtask

    // Monitor: compare whatever the DUTs present against queued predictions.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("freeze_front", e.cyc, b16.freeze_front, e.ff);
                chk("freeze_back",  e.cyc, b16.freeze_back,  e.fb);
                chk("flush_ifid",   e.cyc, b16.flush_ifid,   e.fi);
                chk("flush_idex",   e.cyc, b16.flush_idex,   e.fx);
                chk("mem_busy",     e.cyc, b16.mem_busy,     e.busy);
                chk("hazard_stalls",    e.cyc, b16.hazard_stalls,    sat(e.hz, 16));
                chk("mem_stall_cycles", e.cyc, b16.mem_stall_cycles, sat(e.ms, 16));
                chk("branch_flushes",   e.cyc, b16.branch_flushes,   sat(e.bf, 16));
                chk("sat_hazard_stalls",    e.cyc, b2.hazard_stalls,    sat(e.hz, 2));
                chk("sat_mem_stall_cycles", e.cyc, b2.mem_stall_cycles, sat(e.ms, 2));
                chk("sat_branch_flushes",   e.cyc, b2.branch_flushes,   sat(e.bf, 2));
                chk("sat_freeze_front", e.cyc, b2.freeze_front, e.ff);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        stim_t hz;

        s = idle();
        s.rst = 1'b1;
        step(s);
        step(s);
        step(idle());

        // Load-use with forwarding: one stall cycle, then the load has moved on.
        s = idle();
        s.fwd_en = 1; s.exe_mem_read = 1; s.exe_wb = 1; s.exe_dest = 3;
        s.src1 = 3; s.use1 = 1;
        step(s);
        step(idle());

        // No forwarding: pending MEM write blocks; with forwarding and no load it does not.
        s = idle();
        s.mem_wb = 1; s.mem_dest = 5; s.src2 = 5; s.use2 = 1;
        step(s);
        s.fwd_en = 1;
        step(s);
        step(idle());

        // Slow access: entry + 3 not-ready cycles, then ready, then a back-to-back access.
        s = idle();
        s.mem_req = 1;
        for (int i = 0; i < 4; i++) step(s);
        s.mem_ready = 1;
        step(s);
        s.mem_ready = 0;
        step(s);
        s.mem_ready = 1;
        step(s);
        step(idle());

        // Branch wins over a simultaneous hazard.
        hz = idle();
        hz.mem_wb = 1; hz.mem_dest = 7; hz.src1 = 7; hz.use1 = 1;
        s = hz;
        s.branch = 1;
        step(s);
        step(idle());

        // Branch held across WAIT: flushed only in the mem_ready cycle.
        s = idle();
        s.branch = 1; s.mem_req = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.mem_ready = 1;
        step(s);
        step(idle());

        // Reset while parked in WAIT.
        s = idle();
        s.mem_req = 1;
        step(s);
        step(s);
        s.rst = 1;
        step(s);
        s.rst = 0; s.mem_req = 0;
        step(s);
        step(idle());

        // Hold a hazard for 6 cycles from clean counters: narrow counter pins at 3.
        s = idle();
        s.rst = 1;
        step(s);
        for (int i = 0; i < 6; i++) step(hz);
        step(idle());

        // Randomised traffic over a small register space so hits are frequent.
        for (int i = 0; i < 500; i++) begin
            s.rst          = ($urandom_range(0, 59) == 0);
            s.fwd_en       = 1'($urandom_range(0, 1));
            s.src1         = 4'($urandom_range(0, 3));
            s.src2         = 4'($urandom_range(0, 3));
            s.use1         = 1'($urandom_range(0, 1));
            s.use2         = 1'($urandom_range(0, 1));
            s.exe_wb       = 1'($urandom_range(0, 1));
            s.mem_wb       = 1'($urandom_range(0, 1));
            s.exe_dest     = 4'($urandom_range(0, 3));
            s.mem_dest     = 4'($urandom_range(0, 3));
            s.exe_mem_read = 1'($urandom_range(0, 1));
            s.branch       = ($urandom_range(0, 4) == 0);
            s.mem_req      = ($urandom_range(0, 2) == 0);
            s.mem_ready    = 1'($urandom_range(0, 1));
            step(s);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", cyc, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
